// File: rtl/overcooked_pkg.sv
// overcooked_pkg: shared constants for the kitchen grid.
//   - Grid object codes G_EMPTY..G_EXTINGUISHER (4-bit).
//   - Grid geometry GRID_W x GRID_H.
//   - Command opcodes.
//   - State encoding for the grid_state_keeper control FSM.
package overcooked_pkg;

    localparam int GRID_W = 13;
    localparam int GRID_H = 8;

    localparam logic [3:0] G_EMPTY          = 4'd0;
    localparam logic [3:0] G_ONION_WHOLE    = 4'd1;
    localparam logic [3:0] G_ONION_CHOPPED  = 4'd2;
    localparam logic [3:0] G_PLATE          = 4'd3;
    localparam logic [3:0] G_PLATE_SOUP     = 4'd4;
    localparam logic [3:0] G_POT_EMPTY      = 4'd5;
    localparam logic [3:0] G_POT_RAW        = 4'd6;
    localparam logic [3:0] G_POT_COOKED     = 4'd7;
    localparam logic [3:0] G_POT_FIRE       = 4'd8;
    localparam logic [3:0] G_BIN            = 4'd9;
    localparam logic [3:0] G_EXTINGUISHER   = 4'd10;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_AGE  = 1'b1
    } gsk_state_t;

endpackage

// File: rtl/pot_slot.sv
// pot_slot: one pot-tracking slot (cell position, tick counter, cook/burn decision).
// Optional feature: POT_BURN_EN -- when defined, cooked pots keep counting and turn
// to G_POT_FIRE after BURN_TICKS; otherwise the slot is released once the pot is cooked.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   age_en          this slot is being visited by the current aging pass
//   alloc_en        (re)start tracking at alloc_x/alloc_y with count 0
//   cell_obj        current grid contents at the tracked cell
//   valid_out, x_out, y_out   tracking state
//   upd_en_out, upd_obj_out   grid write request issued while age_en is high
module pot_slot
    import overcooked_pkg::*;
#(
    parameter int COOK_TICKS = 300,
    parameter int BURN_TICKS = 600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       age_en,
    input  logic       alloc_en,
    input  logic [3:0] alloc_x,
    input  logic [2:0] alloc_y,
    input  logic [3:0] cell_obj,
    output logic       valid_out,
    output logic [3:0] x_out,
    output logic [2:0] y_out,
    output logic       upd_en_out,
    output logic [3:0] upd_obj_out
);

    localparam logic [15:0] COOK_LIM = 16'(COOK_TICKS);
    localparam logic [15:0] BURN_LIM = 16'(BURN_TICKS);

    logic        valid_q, valid_d;
    logic [3:0]  x_q, x_d;
    logic [2:0]  y_q, y_d;
    logic [15:0] count_q, count_d;
    logic [15:0] count_inc;
    logic [15:0] limit;
    logic        hit;

    always_comb begin
        count_inc   = count_q + 16'd1;
        // The threshold depends on which phase the pot is in.
        limit       = (cell_obj == G_POT_RAW) ? COOK_LIM : BURN_LIM;
        hit         = (count_inc == limit);
        valid_d     = valid_q;
        x_d         = x_q;
        y_d         = y_q;
        count_d     = count_q;
        upd_en_out  = 1'b0;
        upd_obj_out = G_EMPTY;
        if (alloc_en) begin
            valid_d = 1'b1;
            x_d     = alloc_x;
            y_d     = alloc_y;
            count_d = 16'd0;
        end else if (age_en && valid_q) begin
            case (cell_obj)
                G_POT_RAW: begin
                    if (hit) begin
                        upd_en_out  = 1'b1;
                        upd_obj_out = G_POT_COOKED;
                        count_d     = 16'd0;
`ifndef POT_BURN_EN
                        valid_d     = 1'b0;
`endif
                    end else begin
                        count_d = count_inc;
                    end
                end
                G_POT_COOKED: begin
`ifdef POT_BURN_EN
                    if (hit) begin
                        upd_en_out  = 1'b1;
                        upd_obj_out = G_POT_FIRE;
                        count_d     = 16'd0;
                        valid_d     = 1'b0;
                    end else begin
                        count_d = count_inc;
                    end
`else
                    valid_d = 1'b0;
`endif
                end
                // The pot was replaced or cleared behind our back: stop tracking.
                default: valid_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            x_q     <= 4'd0;
            y_q     <= 3'd0;
            count_q <= 16'd0;
        end else begin
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            count_q <= count_d;
        end
    end

    assign valid_out = valid_q;
    assign x_out     = x_q;
    assign y_out     = y_q;

endmodule

// File: rtl/grid_state_keeper.sv
// grid_state_keeper: owns the 13x8 object grid, serves READ/WRITE/CLEAR commands
// and ages tracked pots once per game tick (one slot per cycle).
// Optional feature: POT_BURN_EN (see pot_slot) enables cooked -> fire burning.
// Ports:
//   pixel_clk_in, rst_n_in       clock, asynchronous active-low reset
//   tick_in                      one-cycle game tick strobe
//   cmd_valid_in/cmd_ready_out   command handshake; cmd_op_in/x/y/obj command fields
//   rsp_valid_out, rsp_obj_out, rsp_err_out   one-cycle response with prior cell value
//   object_grid_out              full grid for the sprite renderer
//   slots_full_out               sticky: a pot was written with no free slot
module grid_state_keeper
    import overcooked_pkg::*;
#(
    parameter int POT_SLOTS  = 4,
    parameter int COOK_TICKS = 300,
    parameter int BURN_TICKS = 600
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_n_in,
    input  logic                   tick_in,
    input  logic                   cmd_valid_in,
    output logic                   cmd_ready_out,
    input  logic [1:0]             cmd_op_in,
    input  logic [3:0]             cmd_x_in,
    input  logic [2:0]             cmd_y_in,
    input  logic [3:0]             cmd_obj_in,
    output logic                   rsp_valid_out,
    output logic [3:0]             rsp_obj_out,
    output logic                   rsp_err_out,
    output logic [7:0][12:0][3:0]  object_grid_out,
    output logic                   slots_full_out
);

    localparam int SLOT_W = (POT_SLOTS > 1) ? $clog2(POT_SLOTS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(POT_SLOTS - 1);

    gsk_state_t           state_q, state_d;
    logic [SLOT_W-1:0]    slot_idx_q, slot_idx_d;
    logic                 pend_q, pend_d;
    logic [7:0][12:0][3:0] grid_q, grid_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [3:0]           rsp_obj_q, rsp_obj_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 full_q, full_d;

    logic [POT_SLOTS-1:0] slot_valid, slot_age, slot_alloc, slot_upd;
    logic [3:0]           slot_x [POT_SLOTS];
    logic [2:0]           slot_y [POT_SLOTS];
    logic [3:0]           slot_cell [POT_SLOTS];
    logic [3:0]           slot_upd_obj [POT_SLOTS];

    logic                 accept, cmd_err, pot_wr;
    logic [3:0]           cell_prior;
    logic                 match_any, free_any;
    logic [SLOT_W-1:0]    match_idx, free_idx;

    // A pending or arriving tick takes the cycle, so ready drops combinationally.
    assign cmd_ready_out = rst_n_in && (state_q == ST_IDLE) && !pend_q && !tick_in;
    assign accept        = cmd_valid_in && cmd_ready_out;
    assign cmd_err       = (cmd_op_in == OP_RSVD) || (cmd_x_in > 4'(GRID_W - 1));
    assign cell_prior    = cmd_err ? G_EMPTY : grid_q[cmd_y_in][cmd_x_in];
    assign pot_wr        = accept && !cmd_err && (cmd_op_in == OP_WRITE) &&
                           ((cmd_obj_in == G_POT_RAW) || (cmd_obj_in == G_POT_COOKED));

    // Slot selection: reuse the slot already on this cell, else the lowest free one.
    always_comb begin
        match_any  = 1'b0;
        match_idx  = '0;
        free_any   = 1'b0;
        free_idx   = '0;
        slot_alloc = '0;
        for (int i = POT_SLOTS - 1; i >= 0; i--) begin
            if (slot_valid[i] && (slot_x[i] == cmd_x_in) && (slot_y[i] == cmd_y_in)) begin
                match_any = 1'b1;
                match_idx = SLOT_W'(i);
            end
            if (!slot_valid[i]) begin
                free_any = 1'b1;
                free_idx = SLOT_W'(i);
            end
        end
        if (pot_wr) begin
            if (match_any)     slot_alloc[match_idx] = 1'b1;
            else if (free_any) slot_alloc[free_idx]  = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_idx_d  = slot_idx_q;
        pend_d      = pend_q;
        grid_d      = grid_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_obj_d   = rsp_obj_q;
        full_d      = full_q;
        slot_age    = '0;
        case (state_q)
            ST_IDLE: begin
                if (tick_in || pend_q) begin
                    state_d    = ST_AGE;
                    slot_idx_d = '0;
                    pend_d     = 1'b0;
                end else if (accept) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = cmd_err;
                    rsp_obj_d   = cell_prior;
                    if (!cmd_err) begin
                        if (cmd_op_in == OP_WRITE) grid_d[cmd_y_in][cmd_x_in] = cmd_obj_in;
                        if (cmd_op_in == OP_CLEAR) grid_d[cmd_y_in][cmd_x_in] = G_EMPTY;
                    end
                    if (pot_wr && !match_any && !free_any) full_d = 1'b1;
                end
            end
            ST_AGE: begin
                slot_age[slot_idx_q] = 1'b1;
                // Only one tick can be remembered; extra ticks this pass are lost.
                if (tick_in) pend_d = 1'b1;
                if (slot_upd[slot_idx_q])
                    grid_d[slot_y[slot_idx_q]][slot_x[slot_idx_q]] = slot_upd_obj[slot_idx_q];
                if (slot_idx_q == LAST_SLOT) state_d = ST_IDLE;
                else                         slot_idx_d = slot_idx_q + SLOT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            slot_idx_q  <= '0;
            pend_q      <= 1'b0;
            grid_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_obj_q   <= 4'd0;
            rsp_err_q   <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_idx_q  <= slot_idx_d;
            pend_q      <= pend_d;
            grid_q      <= grid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_obj_q   <= rsp_obj_d;
            rsp_err_q   <= rsp_err_d;
            full_q      <= full_d;
        end
    end

    for (genvar i = 0; i < POT_SLOTS; i++) begin : g_slot
        assign slot_cell[i] = grid_q[slot_y[i]][slot_x[i]];
        pot_slot #(
            .COOK_TICKS (COOK_TICKS),
            .BURN_TICKS (BURN_TICKS)
        ) u_slot (
            .clk         (pixel_clk_in),
            .rst_n       (rst_n_in),
            .age_en      (slot_age[i]),
            .alloc_en    (slot_alloc[i]),
            .alloc_x     (cmd_x_in),
            .alloc_y     (cmd_y_in),
            .cell_obj    (slot_cell[i]),
            .valid_out   (slot_valid[i]),
            .x_out       (slot_x[i]),
            .y_out       (slot_y[i]),
            .upd_en_out  (slot_upd[i]),
            .upd_obj_out (slot_upd_obj[i])
        );
    end

    assign rsp_valid_out   = rsp_valid_q;
    assign rsp_obj_out     = rsp_obj_q;
    assign rsp_err_out     = rsp_err_q;
    assign object_grid_out = grid_q;
    assign slots_full_out  = full_q;

endmodule

// File: tb/tb_grid_state_keeper.sv
module tb_grid_state_keeper;
    import overcooked_pkg::*;

    localparam int POT  = 4;
    localparam int COOK = 3;
    localparam int BURN = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  tick_in = 1'b0;
    logic                  cmd_valid_in = 1'b0;
    logic                  cmd_ready_out;
    logic [1:0]            cmd_op_in = 2'd0;
    logic [3:0]            cmd_x_in = 4'd0;
    logic [2:0]            cmd_y_in = 3'd0;
    logic [3:0]            cmd_obj_in = 4'd0;
    logic                  rsp_valid_out;
    logic [3:0]            rsp_obj_out;
    logic                  rsp_err_out;
    logic [7:0][12:0][3:0] object_grid_out;
    logic                  slots_full_out;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    grid_state_keeper #(.POT_SLOTS(POT), .COOK_TICKS(COOK), .BURN_TICKS(BURN)) dut (
        .pixel_clk_in    (clk),
        .rst_n_in        (rst_n),
        .tick_in         (tick_in),
        .cmd_valid_in    (cmd_valid_in),
        .cmd_ready_out   (cmd_ready_out),
        .cmd_op_in       (cmd_op_in),
        .cmd_x_in        (cmd_x_in),
        .cmd_y_in        (cmd_y_in),
        .cmd_obj_in      (cmd_obj_in),
        .rsp_valid_out   (rsp_valid_out),
        .rsp_obj_out     (rsp_obj_out),
        .rsp_err_out     (rsp_err_out),
        .object_grid_out (object_grid_out),
        .slots_full_out  (slots_full_out)
    );

    // ---------------- behavioural model ----------------
    int m_grid [8][13];
    bit s_v [POT];
    int s_x [POT];
    int s_y [POT];
    int s_c [POT];
    int busy = 0;     // aging-pass cycles still to run
    bit pend = 0;
    bit full = 0;
    bit e_rv = 0;
    bit e_err = 0;
    int e_obj = 0;

    task automatic model_reset();
        foreach (m_grid[y, x]) m_grid[y][x] = 0;
        for (int i = 0; i < POT; i++) begin s_v[i] = 0; s_c[i] = 0; end
        busy = 0; pend = 0; full = 0; e_rv = 0; e_err = 0; e_obj = 0;
    endtask

    task automatic track(int x, int y);
        for (int i = 0; i < POT; i++)
            if (s_v[i] && s_x[i] == x && s_y[i] == y) begin s_c[i] = 0; return; end
        for (int i = 0; i < POT; i++)
            if (!s_v[i]) begin s_v[i] = 1; s_x[i] = x; s_y[i] = y; s_c[i] = 0; return; end
        full = 1;
    endtask

    // A whole pass at once: each tracked cell is distinct, so slot order is irrelevant.
    task automatic age_pass();
        for (int i = 0; i < POT; i++) begin
            if (!s_v[i]) continue;
            if (m_grid[s_y[i]][s_x[i]] == int'(G_POT_RAW)) begin
                s_c[i]++;
                if (s_c[i] == COOK) begin
                    m_grid[s_y[i]][s_x[i]] = int'(G_POT_COOKED);
                    s_c[i] = 0;
`ifndef POT_BURN_EN
                    s_v[i] = 0;
`endif
                end
            end else if (m_grid[s_y[i]][s_x[i]] == int'(G_POT_COOKED)) begin
`ifdef POT_BURN_EN
                s_c[i]++;
                if (s_c[i] == BURN) begin
                    m_grid[s_y[i]][s_x[i]] = int'(G_POT_FIRE);
                    s_v[i] = 0;
                end
`else
                s_v[i] = 0;
`endif
            end else begin
                s_v[i] = 0;
            end
        end
    endtask

    task automatic do_cmd();
        int x, y, op, o;
        x = int'(cmd_x_in); y = int'(cmd_y_in); op = int'(cmd_op_in); o = int'(cmd_obj_in);
        e_rv = 1;
        if (op == 3 || x > 12) begin e_err = 1; e_obj = 0; return; end
        e_obj = m_grid[y][x];
        if (op == 1) begin
            m_grid[y][x] = o;
            if (o == int'(G_POT_RAW) || o == int'(G_POT_COOKED)) track(x, y);
        end else if (op == 2) begin
            m_grid[y][x] = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            e_rv = 0; e_err = 0;
            if (busy > 0) begin
                busy--;
                if (tick_in) pend = 1;
            end else if (tick_in || pend) begin
                pend = 0;
                busy = POT;
                age_pass();
            end else if (cmd_valid_in) begin
                do_cmd();
            end
        end
    end

    function automatic logic [7:0][12:0][3:0] model_grid_vec();
        logic [7:0][12:0][3:0] v;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 13; x++) v[y][x] = 4'(m_grid[y][x]);
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [7:0][12:0][3:0] eg;
        chk("ready", int'(cmd_ready_out),
            int'(rst_n && busy == 0 && !pend && !tick_in));
        chk("rsp_valid", int'(rsp_valid_out), int'(e_rv));
        chk("slots_full", int'(slots_full_out), int'(full));
        if (e_rv) begin
            chk("rsp_obj", int'(rsp_obj_out), e_obj);
            chk("rsp_err", int'(rsp_err_out), int'(e_err));
        end
        if (busy == 0) begin
            eg = model_grid_vec();
            tot_cnt++;
            if (object_grid_out === eg) pass_cnt++;
            else $display("FAIL grid: got %h, expected %h at %0t", object_grid_out, eg, $time);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic cyc();
        @(posedge clk); #2;
    endtask

    task automatic send(logic [1:0] op, logic [3:0] x, logic [2:0] y, logic [3:0] o);
        int n = 0;
        cmd_valid_in = 1'b1; cmd_op_in = op; cmd_x_in = x; cmd_y_in = y; cmd_obj_in = o;
        #1;
        while (!cmd_ready_out && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("send_timeout", n, 0);
        cyc();
        cmd_valid_in = 1'b0;
    endtask

    task automatic tick_once();
        tick_in = 1'b1; cyc(); tick_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready_out && n < 50) begin cyc(); n++; end
        if (n >= 50) chk("idle_timeout", n, 0);
    endtask

    task automatic tick_pass();
        tick_once(); wait_idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cyc(); cyc(); rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_ready", int'(cmd_ready_out), 0);
        chk("reset_grid_zero", int'(object_grid_out == '0), 1);
        chk("reset_rsp_obj", int'(rsp_obj_out), 0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", int'(cmd_ready_out), 1);
        cyc();

        // write then read back
        send(OP_WRITE, 4'd3, 3'd2, G_ONION_WHOLE);
        chk("write_prior", int'(rsp_obj_out), 0);
        send(OP_READ, 4'd3, 3'd2, 4'd0);
        chk("read_value", int'(rsp_obj_out), 1);
        chk("grid_2_3", int'(object_grid_out[2][3]), 1);

        // cooking
        send(OP_WRITE, 4'd5, 3'd1, G_POT_RAW);
        tick_pass(); tick_pass();
        chk("raw_after_2", int'(object_grid_out[1][5]), 6);
        tick_pass();
        chk("cooked_after_3", int'(object_grid_out[1][5]), 7);
        tick_pass(); tick_pass();
`ifdef POT_BURN_EN
        chk("fire_after_burn", int'(object_grid_out[1][5]), 8);
`else
        chk("cooked_stays", int'(object_grid_out[1][5]), 7);
`endif

        // error commands
        send(OP_WRITE, 4'd13, 3'd0, G_PLATE);
        chk("err_x", int'(rsp_err_out), 1);
        chk("err_x_obj", int'(rsp_obj_out), 0);
        send(OP_RSVD, 4'd0, 3'd0, G_PLATE);
        chk("err_op3", int'(rsp_err_out), 1);
        chk("grid_0_0_untouched", int'(object_grid_out[0][0]), 0);

        // slot exhaustion
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("not_full_yet", int'(slots_full_out), 0);
            send(OP_WRITE, 4'(i), 3'd0, G_POT_RAW);
        end
        chk("slots_full", int'(slots_full_out), 1);
        for (int i = 0; i < 10; i++) tick_pass();
        chk("fifth_pot_untracked", int'(object_grid_out[0][4]), 6);
        chk("first_pot_done", int'(object_grid_out[0][0]),
`ifdef POT_BURN_EN
            8
`else
            7
`endif
        );

        // tick beats command, extra tick mid-pass
        do_reset();
        cyc();
        tick_in = 1'b1; cmd_valid_in = 1'b1; cmd_op_in = OP_READ; cmd_x_in = 4'd0; cmd_y_in = 3'd0;
        cyc();
        tick_in = 1'b0;
        chk("ready_low_in_age", int'(cmd_ready_out), 0);
        n = 0;
        while (!rsp_valid_out && n < 50) begin
            tick_in = (n == 1);
            cyc();
            n++;
        end
        tick_in = 1'b0;
        cmd_valid_in = 1'b0;
        chk("two_pass_latency", n, 2 * (POT + 1));

        // reset in the middle of an aging pass
        send(OP_WRITE, 4'd7, 3'd7, G_POT_RAW);
        tick_pass(); tick_pass();
        tick_once();
        cyc();
        rst_n = 1'b0;
        #1;
        chk("midage_rst_grid", int'(object_grid_out == '0), 1);
        chk("midage_rst_ready", int'(cmd_ready_out), 0);
        cyc(); cyc();
        rst_n = 1'b1;
        #1;
        chk("midage_ready_after", int'(cmd_ready_out), 1);
        send(OP_WRITE, 4'd7, 3'd7, G_POT_RAW);
        tick_pass();
        chk("slot_restart_raw", int'(object_grid_out[7][7]), 6);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            int r;
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                continue;
            end
            tick_in = ($urandom_range(0, 5) == 0);
            cmd_valid_in = $urandom_range(0, 1);
            r = $urandom_range(0, 15);
            cmd_op_in = (r < 4) ? OP_READ : (r < 12) ? OP_WRITE : (r < 15) ? OP_CLEAR : OP_RSVD;
            cmd_x_in = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 3));
            cmd_y_in = 3'($urandom_range(0, 1));
            r = $urandom_range(0, 19);
            cmd_obj_in = (r < 10) ? G_POT_RAW : (r < 13) ? G_POT_COOKED : 4'($urandom_range(0, 10));
            cyc();
        end
        tick_in = 1'b0;
        cmd_valid_in = 1'b0;
        repeat (12) cyc();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
